io_reg_bank: RTL and testbench
==============================

Name: io_reg_bank

Overview:
- Parametrised Wishbone I/O-space register bank; replaces the single hard-wired I/O stub register in the board top level.
- Provides NREGS 16-bit registers at consecutive even I/O ports from BASE_ADR, with proper byte-lane writes, registered single-pulse ack, and read-only status slots.
- Sits on the CPU bus beside the memory map; the top level gates stb with mio and muxes dat_o using hit_o.
- Exposes all register contents and per-register write pulses to fabric, for example the LCD debug display.

Parameters:
- NREGS, 4: number of 16-bit registers (1..16).
- BASE_ADR, 16'h00b6: I/O byte address of register 0; must be even. Register i is at BASE_ADR+2*i.
- RST_VAL, 16'h0000: reset value of every writable register.
- RO_MASK, {NREGS{1'b0}}: bit i=1 makes register i read-only. It reads stat_i slice i, and writes to it are acked and discarded.

Ports:
- clk_i  in  1  bus clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- adr_i  in  20  byte address; only [15:0] are decoded.
- dat_i  in  16  write data; byte writes use [7:0].
- dat_o  out  16  read data, registered, valid while ack_o=1.
- we_i  in  1  write enable.
- stb_i  in  1  strobe, already qualified with mio by the top level.
- byte_i  in  1  1 = byte access, 0 = word access.
- ack_o  out  1  transfer acknowledge, one-cycle pulse.
- hit_o  out  1  combinational: adr_i[15:0] falls in the bank window.
- stat_i  in  16*NREGS  status values for read-only slots.
- regs_o  out  16*NREGS  current register contents (RO slots output stat_i).
- wr_pulse_o  out  NREGS  one-cycle pulse when register i is written (writable slots only).

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - writable registers = RST_VAL
  - ack_o = 0, dat_o = 0, wr_pulse_o = 0
  - an access in progress is abandoned with no ack.
- Decode:
  - idx = (adr_i[15:0]-BASE_ADR)>>1.
  - hit_o = stb_i & (adr_i[15:0] >= BASE_ADR) & (adr_i[15:0] < BASE_ADR+2*NREGS).
  - adr_i[19:16] is ignored.
- Handshake:
  - ack_o <= hit_o & ~ack_o on each rising edge.
  - Latency is 1 cycle from the first sampled stb.
  - ack_o is never high on two consecutive cycles. If stb is held through the ack cycle, a second access starts only on the following cycle.
  - Non-hit strobes are never acked.
- Write, performed on the same edge that raises ack_o:
  - Word access at an even address: reg[idx] <= dat_i.
  - Byte access with adr_i[0]=0: reg[idx][7:0] <= dat_i[7:0].
  - Byte access with adr_i[0]=1: reg[idx][15:8] <= dat_i[7:0].
  - Word access at an odd address: acked, no write, no pulse.
  - RO slot: acked, no write, no pulse.
- wr_pulse_o[idx] is high for exactly the cycle ack_o is high on a completed write to a writable slot.
- Read, with dat_o loaded on the ack edge:
  - Word access: reg[idx].
  - Byte access, adr_i[0]=0: {8'h00, reg[idx][7:0]}.
  - Byte access, adr_i[0]=1: {8'h00, reg[idx][15:8]}.
  - Word access at an odd address: 16'h0000.
  - RO slot: the value is taken from stat_i sampled on the ack edge.
- dat_o holds its value after ack; only the cycle with ack_o=1 is significant.
- Simultaneous events: a write and the fabric reading regs_o in the same cycle → regs_o shows the old value until the edge, the new value from the cycle after.
- Window boundaries: BASE_ADR-1 and BASE_ADR+2*NREGS are misses; the last odd byte BASE_ADR+2*NREGS-1 is a hit.

Decomposition:
- Shared package io_bank_pkg:
  - register width constant (16)
  - address-window helper function
  - byte-lane encoding constants: LANE_LO, LANE_HI, LANE_WORD, LANE_BAD.
- One natural sub-module, io_reg_word:
  - single 16-bit register with lane select, write strobe, async active-low reset, RST_VAL parameter and wr_pulse output.
  - Instantiated NREGS times by a generate loop, skipped for RO_MASK slots.

Test Plan:
- Reset: hold rst_n_i=0 for 3 cycles, then release → regs_o all 16'h0000, ack_o=0, wr_pulse_o=0; assert reset mid-access → no ack follows.
- Word write then read: write 16'hbeef at 16'h00b6 → ack 1 cycle later, wr_pulse_o[0] for 1 cycle; word read of 16'h00b6 → dat_o=16'hbeef with ack.
- Byte lanes:
  - byte write 8'h5a to 16'h00b7 over 16'h1234 → reg0=16'h5a34.
  - byte read of 16'h00b7 → 16'h005a.
  - byte read of 16'h00b6 → 16'h0034.
- Held strobe: stb held 6 cycles on a hit → ack_o pattern 0,1,0,1,0,1; no two consecutive acks.
- Window edges (NREGS=4):
  - 16'h00b5 and 16'h00be → hit_o=0, no ack.
  - 16'h00bd byte write → reg3 high byte written.
  - adr 20'h100b6 → hits reg0.
- RO and misaligned (RO_MASK=4'b0010):
  - write 16'hffff to 16'h00b8 → acked, no pulse, reads stat_i[31:16]=16'hc0de.
  - word write at 16'h00b9 → acked, no change, read returns 16'h0000.

Source files
------------

// File: rtl/io_bank_pkg.sv
// Shared definitions for the Wishbone I/O register bank: register width,
// byte-lane encoding and the address-window decode helper.
package io_bank_pkg;

   localparam int REG_W = 16;

   typedef enum logic [1:0] {
      LANE_LO   = 2'd0,
      LANE_HI   = 2'd1,
      LANE_WORD = 2'd2,
      LANE_BAD  = 2'd3
   } lane_e;

   // 17-bit arithmetic so a window touching 16'hffff cannot wrap
   function automatic logic in_window(input logic [15:0] adr,
                                      input logic [15:0] base,
                                      input logic [4:0]  nregs);
      logic [16:0] lim;
      lim = {1'b0, base} + {11'd0, nregs, 1'b0};
      return ({1'b0, adr} >= {1'b0, base}) && ({1'b0, adr} < lim);
   endfunction

   function automatic lane_e lane_of(input logic byte_acc, input logic a0);
      lane_e lane;
      case ({byte_acc, a0})
         2'b10:   lane = LANE_LO;
         2'b11:   lane = LANE_HI;
         2'b00:   lane = LANE_WORD;
         default: lane = LANE_BAD;
      endcase
      return lane;
   endfunction

endpackage

// File: rtl/io_reg_word.sv
// One 16-bit bank register with byte-lane writes and a write pulse that
// rises on the same edge as the bus acknowledge.
module io_reg_word
   import io_bank_pkg::*;
#(
   parameter logic [15:0] RST_VAL = 16'h0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  lane_e         lane,
   input  logic [15:0]   din,
   output logic [15:0]   q,
   output logic          wr_pulse
);

   logic [15:0] q_r;
   logic        pulse_r;

   // Register update per lane; a misaligned word lane is discarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r     <= RST_VAL;
         pulse_r <= 1'b0;
      end else begin
         pulse_r <= 1'b0;
         if (we) begin
            case (lane)
               LANE_LO: begin
                  q_r[7:0] <= din[7:0];
                  pulse_r  <= 1'b1;
               end
               LANE_HI: begin
                  q_r[15:8] <= din[7:0];
                  pulse_r   <= 1'b1;
               end
               LANE_WORD: begin
                  q_r     <= din;
                  pulse_r <= 1'b1;
               end
               default: begin
                  q_r     <= q_r;
                  pulse_r <= 1'b0;
               end
            endcase
         end else begin
            q_r <= q_r;
         end
      end
   end

   assign q        = q_r;
   assign wr_pulse = pulse_r;

endmodule

// File: rtl/io_reg_bank.sv
// Parametrised Wishbone I/O-space register bank with byte lanes, single-pulse
// ack, read-only status slots and per-register write pulses to fabric.
module io_reg_bank
   import io_bank_pkg::*;
#(
   parameter int                NREGS    = 4,
   parameter logic [15:0]       BASE_ADR = 16'h00b6,
   parameter logic [15:0]       RST_VAL  = 16'h0000,
   parameter logic [NREGS-1:0]  RO_MASK  = {NREGS{1'b0}}
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [19:0]           adr_i,
   input  logic [15:0]           dat_i,
   output logic [15:0]           dat_o,
   input  logic                  we_i,
   input  logic                  stb_i,
   input  logic                  byte_i,
   output logic                  ack_o,
   output logic                  hit_o,
   input  logic [16*NREGS-1:0]   stat_i,
   output logic [16*NREGS-1:0]   regs_o,
   output logic [NREGS-1:0]      wr_pulse_o
);

   logic        hit_s;
   logic        start_s;
   logic [15:0] off_s;
   logic [3:0]  idx_s;
   lane_e       lane_s;
   logic [15:0] word_s;
   logic [15:0] rd_data_s;
   logic [15:0] regs_s [16];
   logic        ack_r;
   logic [15:0] dat_r;
   logic        unused_s;

   assign hit_s   = stb_i & in_window(adr_i[15:0], BASE_ADR, 5'(NREGS));
   assign off_s   = adr_i[15:0] - BASE_ADR;
   assign idx_s   = off_s[4:1];
   assign lane_s  = lane_of(byte_i, adr_i[0]);
   // A held strobe restarts only after the ack cycle has passed
   assign start_s = hit_s & ~ack_r;

   // Slots beyond NREGS read as zero; RO slots mirror stat_i live
   for (genvar i = 0; i < 16; i++) begin : g_slot
      if (i >= NREGS) begin : g_none
         assign regs_s[i] = 16'h0000;
      end else if (RO_MASK[i]) begin : g_ro
         assign regs_s[i]     = stat_i[16*i +: 16];
         assign wr_pulse_o[i] = 1'b0;
      end else begin : g_rw
         io_reg_word #(
            .RST_VAL (RST_VAL)
         ) u_word (
            .clk      (clk_i),
            .rst_n    (rst_n_i),
            .we       (start_s & we_i & (idx_s == 4'(i))),
            .lane     (lane_s),
            .din      (dat_i),
            .q        (regs_s[i]),
            .wr_pulse (wr_pulse_o[i])
         );
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_out
      assign regs_o[16*i +: 16] = regs_s[i];
   end

   // Read data selection by lane
   always_comb begin
      word_s    = regs_s[idx_s];
      rd_data_s = 16'h0000;
      case (lane_s)
         LANE_LO:   rd_data_s = {8'h00, word_s[7:0]};
         LANE_HI:   rd_data_s = {8'h00, word_s[15:8]};
         LANE_WORD: rd_data_s = word_s;
         default:   rd_data_s = 16'h0000;
      endcase
   end

   // Acknowledge and registered read data
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ack_r <= 1'b0;
         dat_r <= 16'h0000;
      end else begin
         ack_r <= start_s;
         if (start_s && !we_i) begin
            dat_r <= rd_data_s;
         end else begin
            dat_r <= dat_r;
         end
      end
   end

   assign ack_o = ack_r;
   assign dat_o = dat_r;
   assign hit_o = hit_s;

   assign unused_s = ^{adr_i[19:16], off_s[15:5], off_s[0], stat_i};

endmodule

// File: tb/tb_io_reg_bank.sv
// Directed self-checking bench for io_reg_bank (NREGS=4, RO slot 1).
module tb_io_reg_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] adr;
   logic [15:0] dat_w;
   logic [15:0] dat_rd;
   logic        we;
   logic        stb;
   logic        byte_acc;
   logic        ack;
   logic        hit;
   logic [63:0] stat;
   logic [63:0] regs;
   logic [3:0]  wr_pulse;

   int errors = 0;
   int checks = 0;

   io_reg_bank #(
      .NREGS    (4),
      .BASE_ADR (16'h00b6),
      .RST_VAL  (16'h0000),
      .RO_MASK  (4'b0010)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .adr_i      (adr),
      .dat_i      (dat_w),
      .dat_o      (dat_rd),
      .we_i       (we),
      .stb_i      (stb),
      .byte_i     (byte_acc),
      .ack_o      (ack),
      .hit_o      (hit),
      .stat_i     (stat),
      .regs_o     (regs),
      .wr_pulse_o (wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Start an access mid-cycle after a guaranteed idle edge
   task automatic drive(input logic w, input logic b, input logic [19:0] a, input logic [15:0] d);
      @(posedge clk);
      @(negedge clk);
      chk("ack_idle", {63'd0, ack}, 64'd0);
      we = w; byte_acc = b; adr = a; dat_w = d; stb = 1'b1;
      #1;
   endtask

   task automatic edge_done();
      @(posedge clk);
      #1;
      stb = 1'b0;
      we  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; stb = 1'b0; we = 1'b0; byte_acc = 1'b0;
      adr = 20'h00000; dat_w = 16'h0000;
      stat = {16'h4444, 16'h3333, 16'hc0de, 16'h1111};
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_regs", regs, {16'h0000, 16'h0000, 16'hc0de, 16'h0000});
      chk("rst_ack", {63'd0, ack}, 64'd0);
      chk("rst_pulse", {60'd0, wr_pulse}, 64'd0);
      chk("rst_dat", {48'd0, dat_rd}, 64'd0);

      // word write then read
      drive(1'b1, 1'b0, 20'h000b6, 16'hbeef);
      chk("wr_hit", {63'd0, hit}, 64'd1);
      chk("wr_old", {48'd0, regs[15:0]}, 64'h0000);
      edge_done();
      chk("wr_ack", {63'd0, ack}, 64'd1);
      chk("wr_pulse", {60'd0, wr_pulse}, 64'h1);
      chk("wr_reg0", {48'd0, regs[15:0]}, 64'hbeef);
      @(posedge clk); #1;
      chk("wr_ack_drop", {63'd0, ack}, 64'd0);
      chk("wr_pulse_drop", {60'd0, wr_pulse}, 64'h0);
      drive(1'b0, 1'b0, 20'h000b6, 16'h0000);
      edge_done();
      chk("rd_ack", {63'd0, ack}, 64'd1);
      chk("rd_dat", {48'd0, dat_rd}, 64'hbeef);
      chk("rd_pulse", {60'd0, wr_pulse}, 64'h0);

      // byte lanes
      drive(1'b1, 1'b0, 20'h000b6, 16'h1234);
      edge_done();
      drive(1'b1, 1'b1, 20'h000b7, 16'hff5a);
      edge_done();
      chk("bw_ack", {63'd0, ack}, 64'd1);
      chk("bw_pulse", {60'd0, wr_pulse}, 64'h1);
      chk("bw_reg0", {48'd0, regs[15:0]}, 64'h5a34);
      drive(1'b0, 1'b1, 20'h000b7, 16'h0000);
      edge_done();
      chk("br_hi", {48'd0, dat_rd}, 64'h005a);
      drive(1'b0, 1'b1, 20'h000b6, 16'h0000);
      edge_done();
      chk("br_lo", {48'd0, dat_rd}, 64'h0034);

      // held strobe: ack alternates
      drive(1'b0, 1'b0, 20'h000b6, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         chk("held_ack", {63'd0, ack}, {63'd0, 1'(i % 2)});
         @(negedge clk); #1;
      end
      stb = 1'b0;

      // window edges
      drive(1'b0, 1'b0, 20'h000b5, 16'h0000);
      chk("miss_lo_hit", {63'd0, hit}, 64'd0);
      edge_done();
      chk("miss_lo_ack", {63'd0, ack}, 64'd0);
      drive(1'b0, 1'b0, 20'h000be, 16'h0000);
      chk("miss_hi_hit", {63'd0, hit}, 64'd0);
      edge_done();
      chk("miss_hi_ack", {63'd0, ack}, 64'd0);
      drive(1'b1, 1'b1, 20'h000bd, 16'h0077);
      chk("edge_hit", {63'd0, hit}, 64'd1);
      chk("edge_old", {48'd0, regs[63:48]}, 64'h0000);
      edge_done();
      chk("edge_ack", {63'd0, ack}, 64'd1);
      chk("edge_pulse", {60'd0, wr_pulse}, 64'h8);
      chk("edge_reg3", {48'd0, regs[63:48]}, 64'h7700);
      drive(1'b0, 1'b0, 20'h100b6, 16'h0000);
      edge_done();
      chk("alias_ack", {63'd0, ack}, 64'd1);
      chk("alias_dat", {48'd0, dat_rd}, 64'h5a34);

      // read-only slot
      drive(1'b1, 1'b0, 20'h000b8, 16'hffff);
      edge_done();
      chk("ro_ack", {63'd0, ack}, 64'd1);
      chk("ro_pulse", {60'd0, wr_pulse}, 64'h0);
      chk("ro_regs", {48'd0, regs[31:16]}, 64'hc0de);
      drive(1'b0, 1'b0, 20'h000b8, 16'h0000);
      edge_done();
      chk("ro_rd", {48'd0, dat_rd}, 64'hc0de);

      // misaligned word accesses
      drive(1'b1, 1'b0, 20'h000b7, 16'haaaa);
      edge_done();
      chk("mis_ack", {63'd0, ack}, 64'd1);
      chk("mis_pulse", {60'd0, wr_pulse}, 64'h0);
      chk("mis_reg0", {48'd0, regs[15:0]}, 64'h5a34);
      drive(1'b1, 1'b0, 20'h000b9, 16'haaaa);
      edge_done();
      chk("mis_ro_ack", {63'd0, ack}, 64'd1);
      chk("mis_ro_pulse", {60'd0, wr_pulse}, 64'h0);
      drive(1'b0, 1'b0, 20'h000b9, 16'h0000);
      edge_done();
      chk("mis_rd_ack", {63'd0, ack}, 64'd1);
      chk("mis_rd_dat", {48'd0, dat_rd}, 64'h0000);

      // reset in the middle of an access
      drive(1'b1, 1'b0, 20'h000b6, 16'h9999);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_ack", {63'd0, ack}, 64'd0);
      chk("mid_rst_pulse", {60'd0, wr_pulse}, 64'h0);
      stb = 1'b0; we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_ack2", {63'd0, ack}, 64'd0);
      chk("mid_rst_regs", regs, {16'h0000, 16'h0000, 16'hc0de, 16'h0000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
